// File: rtl/reg_file_p.sv
// Parametrised register file with two combinational read ports, a fixed dst tap, and a hardware clear sweep.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_p #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int DST_IDX = 15
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_err,
    output logic [DATA_W-1:0] dst_out
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DST_ADDR = ADDR_W'(DST_IDX);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] core [DEPTH];

    // During CLEAR every write request is dropped and flagged one cycle later.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                core[i] <= '0;
            end
            state  <= IDLE;
            ptr    <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        core[wr_addr] <= wr_data;
                    end
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    core[ptr] <= '0;
                    wr_err    <= wr_en;
                    if (ptr == LAST_IDX) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == CLEAR);

`ifdef REG_FILE_BYPASS_EN
    logic wr_accept;

    // Only writes that will actually land are forwarded; dropped writes never are.
    assign wr_accept = wr_en && (state == IDLE) && !reset;
    assign rd_a_data = (wr_accept && (rd_a_addr == wr_addr)) ? wr_data : core[rd_a_addr];
    assign rd_b_data = (wr_accept && (rd_b_addr == wr_addr)) ? wr_data : core[rd_b_addr];
    assign dst_out   = (wr_accept && (wr_addr == DST_ADDR)) ? wr_data : core[DST_ADDR];
`else
    assign rd_a_data = core[rd_a_addr];
    assign rd_b_data = core[rd_b_addr];
    assign dst_out   = core[DST_ADDR];
`endif

endmodule
